// File: rtl/lab4_net_ring_router_param.sv
// Three-port ring router: per-input FIFOs, shortest-path routing, round-robin output arbitration.
// Optional forwarding counters are enabled by defining LAB4_NET_RING_ROUTER_STATS_EN.
module lab4_net_ring_router_param #(
  parameter int p_num_routers   = 4,
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 8,
  parameter int p_queue_depth   = 4,
  localparam int p_id_nbits     = (p_num_routers > 2) ? $clog2(p_num_routers) : 1,
  localparam int p_msg_nbits    = p_opaque_nbits + 2 * p_id_nbits + p_payload_nbits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_id_nbits-1:0]  router_id,
  input  logic [p_msg_nbits-1:0] in0_msg,
  input  logic                   in0_val,
  output logic                   in0_rdy,
  input  logic [p_msg_nbits-1:0] in1_msg,
  input  logic                   in1_val,
  output logic                   in1_rdy,
  input  logic [p_msg_nbits-1:0] in2_msg,
  input  logic                   in2_val,
  output logic                   in2_rdy,
  output logic [p_msg_nbits-1:0] out0_msg,
  output logic                   out0_val,
  input  logic                   out0_rdy,
  output logic [p_msg_nbits-1:0] out1_msg,
  output logic                   out1_val,
  input  logic                   out1_rdy,
  output logic [p_msg_nbits-1:0] out2_msg,
  output logic                   out2_val,
  input  logic                   out2_rdy
`ifdef LAB4_NET_RING_ROUTER_STATS_EN
  ,
  output logic [47:0]            stat_fwd_count
`endif
);

  localparam int AW = $clog2(p_queue_depth);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(p_queue_depth);

  logic [p_msg_nbits-1:0] in_msg  [3];
  logic [p_msg_nbits-1:0] out_msg [3];
  logic [p_msg_nbits-1:0] head    [3];
  logic [2:0] in_val, in_rdy, out_val, out_rdy;
  logic [2:0] enq, deq, empty;

  assign in_msg[0] = in0_msg;
  assign in_msg[1] = in1_msg;
  assign in_msg[2] = in2_msg;
  assign in_val    = {in2_val, in1_val, in0_val};
  assign out_rdy   = {out2_rdy, out1_rdy, out0_rdy};
  assign in0_rdy   = in_rdy[0];
  assign in1_rdy   = in_rdy[1];
  assign in2_rdy   = in_rdy[2];
  assign out0_msg  = out_msg[0];
  assign out1_msg  = out_msg[1];
  assign out2_msg  = out_msg[2];
  assign out0_val  = out_val[0];
  assign out1_val  = out_val[1];
  assign out2_val  = out_val[2];

  // ---------------- input queues ----------------
  logic [p_msg_nbits-1:0] mem [3][p_queue_depth];
  logic [AW-1:0]          wr_ptr [3];
  logic [AW-1:0]          rd_ptr [3];
  logic [AW:0]            count  [3];
  logic                   active;

  // Ready comes from registered occupancy only, and stays low until the cycle after reset releases.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      empty[i]  = (count[i] == '0);
      in_rdy[i] = active && (count[i] != FULL_COUNT);
      enq[i]    = in_val[i] && in_rdy[i];
      head[i]   = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      active <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: storage has no reset; emptiness is defined by the pointers/count, so clearing data is unnecessary.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= in_msg[i];
    end
  end

  // ---------------- routing ----------------
  function automatic logic [1:0] route_of(input logic [p_id_nbits-1:0] dest,
                                          input logic [p_id_nbits-1:0] id);
    int d;
    d = int'(dest) - int'(id);
    if (d < 0) d = d + p_num_routers;
    if (d == 0)                  return 2'd1;
    else if (2 * d <= p_num_routers) return 2'd2;  // east wins ties
    else                         return 2'd0;
  endfunction

  logic [1:0] route [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      route[i] = route_of(head[i][p_payload_nbits +: p_id_nbits], router_id);
    end
  end

  // ---------------- output arbitration ----------------
  logic [2:0] req      [3];
  logic [1:0] grant    [3];
  logic [1:0] last     [3];
  logic [1:0] hold_idx [3];
  logic [2:0] hold_v;

  // A stalled output re-grants the same input so its message stays stable.
  always_comb begin : arb
    int   idx;
    logic found;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    deq = '0;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < 3; i++) begin
        req[k][i] = !empty[i] && (route[i] == 2'(k));
      end
      out_val[k] = |req[k];
      grant[k]   = last[k];
      if (hold_v[k]) begin
        grant[k] = hold_idx[k];
      end else begin
        for (int off = 1; off <= 3; off++) begin
          idx = int'(last[k]) + off;
          if (idx >= 3) idx = idx - 3;
          if (!found && req[k][idx]) begin
            grant[k] = 2'(idx);
            found    = 1'b1;
          end
        end
      end
      out_msg[k] = head[grant[k]];
      for (int i = 0; i < 3; i++) begin
        if (out_val[k] && out_rdy[k] && grant[k] == 2'(i)) deq[i] = 1'b1;
      end
    end
  end

  // last = 2 after reset makes input 0 the first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v <= '0;
      for (int k = 0; k < 3; k++) begin
        last[k]     <= 2'd2;
        hold_idx[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        hold_v[k]   <= out_val[k] && !out_rdy[k];
        hold_idx[k] <= grant[k];
        if (out_val[k] && out_rdy[k]) last[k] <= grant[k];
      end
    end
  end

`ifdef LAB4_NET_RING_ROUTER_STATS_EN
  logic [15:0] fwd_cnt [3];

  assign stat_fwd_count = {fwd_cnt[2], fwd_cnt[1], fwd_cnt[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) fwd_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_val[k] && out_rdy[k] && fwd_cnt[k] != 16'hFFFF) fwd_cnt[k] <= fwd_cnt[k] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/lab4_net_ring_router_param.md
LAB4_NET_RING_ROUTER_PARAM -- requirements
Module: lab4_net_ring_router_param

Interface
- REQ-001: p_num_routers, 4: routers in the ring (2..16); p_id_nbits = $clog2(p_num_routers), min 1.
- REQ-002: p_payload_nbits, 32: payload width.
- REQ-003: p_opaque_nbits, 8: opaque header field width.
- REQ-004: p_queue_depth, 4: entries per input queue (power of 2, >=2).
- REQ-005: Message width M = p_opaque_nbits + 2*p_id_nbits + p_payload_nbits, packed {opaque, src, dest, payload} with payload in the LSBs.
- REQ-006: clk  input  1  single clock; all state updates on the rising edge.
- REQ-007: reset  input  1  asynchronous, active-low reset (0 = in reset).
- REQ-008: router_id  input  p_id_nbits  this router's ring position; held stable after reset.
- REQ-009: inK_msg/inK_val input, inK_rdy output, K=0..2, M/1/1: input channels; 0 = west neighbour, 1 = terminal, 2 = east neighbour.
- REQ-010: outK_msg/outK_val output, outK_rdy input, K=0..2, M/1/1: output channels; 0 = west, 1 = terminal, 2 = east.

Function
- REQ-011: Each input SHALL own a FIFO of p_queue_depth entries; a transfer occurs when val && rdy are both high on a rising edge.
- REQ-012: inK_rdy SHALL be high iff queue K is not full; it depends only on registered occupancy, so a full queue refuses an enqueue even in a cycle in which it dequeues.
- REQ-013: The route for a queue head is: dest == router_id -> out1; otherwise with d = (dest - router_id) mod p_num_routers, d < p_num_routers - d -> out2, d > p_num_routers - d -> out0, and a tie -> out2.
- REQ-014: Each output SHALL hold a round-robin arbiter over the three queue heads routed to it; priority starts one past the last input granted.
- REQ-015: The arbiter pointer SHALL advance only on a completed output transfer (outK_val && outK_rdy); a stalled grant keeps the same winner, so outK_msg stays stable while outK_val is high and outK_rdy is low.
- REQ-016: outK_val SHALL be high iff at least one non-empty queue head routes to K; outK_msg equals the granted head; message bits pass unmodified.
- REQ-017: Minimum latency SHALL be 1 cycle from input acceptance to outK_val (no combinational input-to-output path).
- REQ-018: Each queue dequeues at most one message per cycle; up to three distinct outputs may fire in the same cycle.
- REQ-019: Simultaneous enqueue and dequeue on a non-full queue SHALL leave occupancy unchanged; pointers wrap modulo p_queue_depth.
- REQ-020: Order SHALL be preserved per (input, output) pair.

Reset
- REQ-021: While reset = 0, all queues SHALL be empty, all inK_rdy = 0, all outK_val = 0, and all arbiter pointers SHALL give input 0 highest priority.
- REQ-022: inK_rdy SHALL rise in the first cycle after reset deasserts.
- REQ-023: Asserting reset mid-operation SHALL discard all queued messages immediately (asynchronously).

Configuration
- REQ-024: With LAB4_NET_RING_ROUTER_STATS_EN defined, output port stat_fwd_count (48 bits, three 16-bit fields, field K = bits 16K+15:16K) SHALL count completed transfers on outK, saturate at 0xFFFF, and reset to 0.
- REQ-025: Without LAB4_NET_RING_ROUTER_STATS_EN, stat_fwd_count and its counters SHALL be absent; routing behaviour is identical in both builds.

Verification
- REQ-026: Case 1, N=4, id=1: in1 dest=1 -> out1, 1 cycle later, payload intact.
- REQ-027: Case 2, N=4, id=0: dest=1 -> out2; dest=3 -> out0; dest=2 (tie) -> out2.
- REQ-028: Case 3: in0, in1 and in2 all continuously send to out1 -> grants rotate 0,1,2,0...; each input receives 1/3 of the transfers.
- REQ-029: Case 4: depth 4, out2_rdy=0, 5 messages offered on in0 -> 4 accepted, in0_rdy=0; out2_rdy=1 -> messages drain in order and in0_rdy returns 1 cycle after the first dequeue.
- REQ-030: Case 5: reset pulsed low with 3 messages queued -> all val=0 immediately; nothing emitted after release.
- REQ-031: Case 6 (STATS_EN): 70000 transfers on out0 -> field 0 = 0xFFFF; fields 1 and 2 = 0.
